// File: rtl/mc_axi_master.sv
// mc_axi_master
//   Single-outstanding AXI initiator for the memory controller's simplified
//   AXI slave port (AW/W/AR/R only: no B channel, no rready). A local command
//   stream plus a write-data stream become write or read bursts. Read beats
//   are returned registered, one cycle after the slave presents them.
//
//   Handshake rule for every valid/ready pair on this block: a transfer
//   happens on the rising clk edge where valid and ready are both high.
//   valid never waits for ready. Address and length stay stable while
//   awvalid or arvalid is held.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready = IDLE)
//   cmd_write, cmd_addr, cmd_len     direction, start address, beats-1
//   wr_data_valid/wr_data_ready/wr_data   write-data source stream
//   rd_data_valid/rd_data/rd_data_last    read beat output (1-cycle pulse)
//   busy                             high whenever the FSM is not IDLE
//   err_rlast                        1-cycle pulse on an rlast mismatch or
//                                    on rvalid seen outside a read burst
//   axi_aw*/axi_w*/axi_ar*/axi_r*    simplified AXI master signals
//   dbg_state                        current FSM state (IDLE=0, WR_ADDR=1,
//                                    WR_DATA=2, RD_ADDR=3, RD_DATA=4)
module mc_axi_master #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]  cmd_len,
  input  logic                      wr_data_valid,
  output logic                      wr_data_ready,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  output logic                      rd_data_valid,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_data_last,
  output logic                      busy,
  output logic                      err_rlast,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wlast,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic                      axi_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_LEN_WIDTH-1:0]  len_q, len_d;
  logic [AXI_LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      rd_last_q, rd_last_d;
  logic                      err_q, err_d;
  logic                      last_beat;

  // The counter stops at len and never wraps, so len=63 yields 64 beats.
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    rd_last_d     = rd_last_q;
    err_d         = 1'b0;
    cmd_ready     = 1'b0;
    axi_awvalid   = 1'b0;
    axi_arvalid   = 1'b0;
    axi_wvalid    = 1'b0;
    axi_wlast     = 1'b0;
    wr_data_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          state_d = cmd_write ? S_WR_ADDR : S_RD_ADDR;
        end
      end
      S_WR_ADDR: begin
        axi_awvalid = 1'b1;
        if (axi_awready) begin
          state_d = S_WR_DATA;
          cnt_d   = '0;
        end
      end
      S_WR_DATA: begin
        // The write-data stream is passed straight through to W, so the
        // source sees the slave's backpressure in the same cycle.
        axi_wvalid    = wr_data_valid;
        wr_data_ready = axi_wready;
        axi_wlast     = last_beat;
        if (wr_data_valid && axi_wready) begin
          if (last_beat) state_d = S_IDLE;
          else           cnt_d   = cnt_q + AXI_LEN_WIDTH'(1);
        end
      end
      S_RD_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) begin
          state_d = S_RD_DATA;
          cnt_d   = '0;
        end
      end
      S_RD_DATA: begin
        if (axi_rvalid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = axi_rdata;
          rd_last_d  = axi_rlast;
          err_d      = (axi_rlast != last_beat);
          // Completion follows the beat counter; rlast is only checked.
          if (last_beat) state_d = S_IDLE;
          else           cnt_d   = cnt_q + AXI_LEN_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A beat arriving when no read burst is open is dropped and flagged.
    if (state_q != S_RD_DATA && axi_rvalid) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  assign axi_awaddr    = addr_q;
  assign axi_araddr    = addr_q;
  assign axi_awlen     = len_q;
  assign axi_arlen     = len_q;
  assign axi_wdata     = wr_data;
  assign rd_data_valid = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_data_last  = rd_last_q;
  assign err_rlast     = err_q;
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mc_axi_master.sv
module tb_mc_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [19:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic        wr_data_valid, wr_data_ready;
  logic [63:0] wr_data;
  logic        rd_data_valid, rd_data_last, busy, err_rlast;
  logic [63:0] rd_data;
  logic        axi_awvalid, axi_awready;
  logic [5:0]  axi_awlen;
  logic [19:0] axi_awaddr;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [63:0] axi_wdata;
  logic        axi_arvalid, axi_arready;
  logic [5:0]  axi_arlen;
  logic [19:0] axi_araddr;
  logic        axi_rvalid, axi_rlast;
  logic [63:0] axi_rdata;
  logic [2:0]  dbg_state;

  mc_axi_master #(.AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(64), .AXI_LEN_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_data_last(rd_data_last),
    .busy(busy), .err_rlast(err_rlast),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awlen(axi_awlen),
    .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wlast(axi_wlast),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arlen(axi_arlen),
    .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // ---------------- behavioural model + scoreboard ----------------
  // Transaction-level view: is a burst open, which direction, has its
  // address been taken, how many beats remain.
  logic [63:0] exp_q[$];
  bit          m_busy = 0, m_dir = 0, m_addr_done = 0;
  logic [19:0] m_addr = '0;
  logic [5:0]  m_len = '0;
  int          m_left = 0;
  bit          p_rdv = 0, p_last = 0, p_err = 0;
  logic [63:0] p_data = '0;
  // statistics, written only by the monitor
  int          aw_hi_cnt = 0, wbeat_cnt = 0, wlast_cnt = 0, err_cnt = 0, rd_cnt = 0;
  logic [63:0] last_rd_data = '0;
  logic        last_rd_last = 1'b0;

  always @(negedge clk) begin
    bit w_ph, r_ph, a_ph;
    if (!rst_n) begin
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_awvalid", axi_awvalid, 0);
      check("rst_arvalid", axi_arvalid, 0);
      check("rst_wvalid", axi_wvalid, 0);
      check("rst_wlast", axi_wlast, 0);
      check("rst_wr_data_ready", wr_data_ready, 0);
      check("rst_awaddr", {axi_awaddr, axi_awlen}, 0);
      check("rst_araddr", {axi_araddr, axi_arlen}, 0);
      check("rst_rd_data_valid", rd_data_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_data_last", rd_data_last, 0);
      check("rst_err_rlast", err_rlast, 0);
      m_busy = 0; m_addr_done = 0; m_left = 0;
      p_rdv = 0; p_err = 0;
      exp_q.delete();
    end else begin
      a_ph = m_busy && !m_addr_done;
      w_ph = m_busy && m_dir && m_addr_done;
      r_ph = m_busy && !m_dir && m_addr_done;
      check("cmd_ready", cmd_ready, !m_busy);
      check("busy", busy, m_busy);
      check("dbg_idle", dbg_state == 3'd0, !m_busy);
      check("awvalid", axi_awvalid, a_ph && m_dir);
      check("arvalid", axi_arvalid, a_ph && !m_dir);
      if (a_ph && m_dir)  check("aw_addr_len", {axi_awaddr, axi_awlen}, {m_addr, m_len});
      if (a_ph && !m_dir) check("ar_addr_len", {axi_araddr, axi_arlen}, {m_addr, m_len});
      check("wvalid", axi_wvalid, w_ph && wr_data_valid);
      check("wr_data_ready", wr_data_ready, w_ph && axi_wready);
      if (w_ph && wr_data_valid) begin
        check("wdata", axi_wdata, wr_data);
        check("wlast", axi_wlast, m_left == 1);
      end
      check("rd_data_valid", rd_data_valid, p_rdv);
      if (p_rdv) begin
        check("rd_data", rd_data, p_data);
        check("rd_data_last", rd_data_last, p_last);
      end
      check("err_rlast", err_rlast, p_err);
      if (axi_awvalid) aw_hi_cnt++;
      if (err_rlast) err_cnt++;
      if (rd_data_valid) begin
        rd_cnt++;
        last_rd_data = rd_data;
        last_rd_last = rd_data_last;
      end

      // predict the next cycle from this cycle's inputs
      p_rdv = 0; p_err = 0;
      if (axi_rvalid) begin
        if (r_ph) begin
          p_rdv  = 1;
          p_data = axi_rdata;
          p_last = axi_rlast;
          p_err  = (axi_rlast != (m_left == 1));
          m_left--;
          if (m_left == 0) m_busy = 0;
        end else begin
          p_err = 1;
        end
      end
      if (!m_busy && !r_ph) begin
        if (cmd_valid) begin
          m_busy = 1; m_dir = cmd_write; m_addr_done = 0;
          m_addr = cmd_addr; m_len = cmd_len; m_left = int'(cmd_len) + 1;
        end
      end else if (a_ph) begin
        if (m_dir ? axi_awready : axi_arready) m_addr_done = 1;
      end else if (w_ph && wr_data_valid && axi_wready) begin
        wbeat_cnt++;
        if (axi_wlast) wlast_cnt++;
        if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
        else check("w_order", axi_wdata, exp_q.pop_front());
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [63:0] wd[64];
  logic [63:0] rdv_arr[64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 200) begin step(); n++; end
    if (n >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic write_burst(input logic [19:0] a, input logic [5:0] l,
                             input int aw_delay, input bit gaps);
    int idx = 0, cyc = 0, aw_seen = 0;
    bit hs;
    wait_idle();
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = l;
    for (int i = 0; i <= int'(l); i++) exp_q.push_back(wd[i]);
    step();
    cmd_valid = 0;
    while (idx <= int'(l) && cyc < 3000) begin
      axi_awready   = axi_awvalid && (aw_seen >= aw_delay);
      if (axi_awvalid) aw_seen++;
      wr_data_valid = !gaps || ($urandom_range(0, 3) != 0);
      wr_data       = wd[idx];
      axi_wready    = !gaps || ($urandom_range(0, 2) != 0);
      #1;
      hs = axi_wvalid && axi_wready;
      @(posedge clk); #1;
      cyc++;
      if (hs) idx++;
    end
    axi_awready = 0; wr_data_valid = 0; axi_wready = 0;
    if (cyc >= 3000) check("wr_timeout", 1, 0);
  endtask

  task automatic read_burst(input logic [19:0] a, input logic [5:0] l, input int ar_delay,
                            input logic [63:0] mask, input int abort_after, input bit gaps);
    int beat = 0, cyc = 0, ar_seen = 0;
    bit ar_done = 0, hs_ar, hs_r, aborted = 0;
    wait_idle();
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = l;
    step();
    cmd_valid = 0;
    while (beat <= int'(l) && cyc < 3000 && !aborted) begin
      axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
      if (!ar_done) begin
        if (axi_arvalid) begin
          axi_arready = (ar_seen >= ar_delay);
          ar_seen++;
        end
      end else if (!gaps || $urandom_range(0, 2) != 0) begin
        axi_rvalid = 1;
        axi_rdata  = rdv_arr[beat];
        axi_rlast  = mask[beat];
      end
      hs_ar = axi_arready;
      hs_r  = axi_rvalid;
      step();
      cyc++;
      if (hs_ar) ar_done = 1;
      if (hs_r) beat++;
      if (abort_after >= 0 && beat == abort_after) aborted = 1;
    end
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
    if (cyc >= 3000) check("rd_timeout", 1, 0);
    if (aborted) begin
      rst_n = 0;
      #1;
      check("abort_arvalid", axi_arvalid, 0);
      check("abort_rd_data_valid", rd_data_valid, 0);
      check("abort_busy", busy, 0);
      step(); step();
      rst_n = 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s_aw, s_wb, s_wl, s_err, s_rd;
    logic [5:0]  l;
    logic [19:0] a;
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 0; wr_data = '0; axi_awready = 0; axi_wready = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rlast = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();

    // 1: write len=3, awready in the second awvalid cycle
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    s_aw = aw_hi_cnt; s_wb = wbeat_cnt; s_wl = wlast_cnt;
    write_burst(20'h00100, 6'd3, 1, 0);
    check("t1_aw_cycles", aw_hi_cnt - s_aw, 2);
    check("t1_beats", wbeat_cnt - s_wb, 4);
    check("t1_wlast", wlast_cnt - s_wl, 1);
    check("t1_cmd_ready_next", cmd_ready, 1);

    // 2: single-beat read
    rdv_arr[0] = 64'hDEAD;
    s_err = err_cnt; s_rd = rd_cnt;
    read_burst(20'hFFFC0, 6'd0, 0, 64'd1, -1, 0);
    check("t2_busy_fell", busy, 0);
    step();
    check("t2_rd_data", last_rd_data, 64'hDEAD);
    check("t2_rd_last", last_rd_last, 1);
    check("t2_beats", rd_cnt - s_rd, 1);
    check("t2_no_err", err_cnt - s_err, 0);

    // 3: write len=7 with random gaps on both sides
    for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
    s_wb = wbeat_cnt;
    write_burst(20'($urandom), 6'd7, $urandom_range(0, 3), 1);
    check("t3_beats", wbeat_cnt - s_wb, 8);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: read len=3 with rlast on beat 1 and missing on beat 3
    for (int i = 0; i < 4; i++) rdv_arr[i] = {$urandom, $urandom};
    s_err = err_cnt; s_rd = rd_cnt;
    read_burst(20'h0ABCD, 6'd3, 2, 64'b0010, -1, 1);
    step();
    check("t4_err_pulses", err_cnt - s_err, 2);
    check("t4_beats", rd_cnt - s_rd, 4);
    check("t4_exit", busy, 0);

    // 5: 64-beat write, then a read issued immediately
    for (int i = 0; i < 64; i++) wd[i] = {$urandom, $urandom};
    s_wb = wbeat_cnt; s_wl = wlast_cnt;
    write_burst(20'h3F000, 6'd63, 0, 1);
    check("t5_beats", wbeat_cnt - s_wb, 64);
    check("t5_wlast", wlast_cnt - s_wl, 1);
    check("t5_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 6; i++) rdv_arr[i] = {$urandom, $urandom};
    s_rd = rd_cnt;
    read_burst(20'h00040, 6'd5, 0, 64'b100000, -1, 1);
    step();
    check("t5_read_beats", rd_cnt - s_rd, 6);

    // stray rvalid while idle is dropped and flagged
    s_err = err_cnt; s_rd = rd_cnt;
    axi_rvalid = 1; axi_rdata = 64'h5A5A; axi_rlast = 0;
    step();
    axi_rvalid = 0;
    step();
    check("stray_err", err_cnt - s_err, 1);
    check("stray_dropped", rd_cnt - s_rd, 0);

    // random mix
    for (int k = 0; k < 12; k++) begin
      l = 6'($urandom_range(0, 15));
      a = 20'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wd[i] = {$urandom, $urandom};
        write_burst(a, l, $urandom_range(0, 3), 1);
      end else begin
        logic [63:0] mk;
        mk = 64'd1 << l;
        for (int i = 0; i < 16; i++) rdv_arr[i] = {$urandom, $urandom};
        read_burst(a, l, $urandom_range(0, 3), mk, -1, 1);
      end
    end
    step();
    check("rand_queue_empty", exp_q.size(), 0);

    // 6: reset after 2 of 4 read beats, then a normal write
    for (int i = 0; i < 4; i++) rdv_arr[i] = {$urandom, $urandom};
    read_burst(20'h01230, 6'd3, 0, 64'b1000, 2, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) wd[i] = {$urandom, $urandom};
    s_wb = wbeat_cnt;
    write_burst(20'h04560, 6'd2, 1, 1);
    check("t6_write_beats", wbeat_cnt - s_wb, 3);
    step();
    check("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
